run_dump_ctrl: RTL

//  Sequences one processor test run. On start it clears the CPU and the regfile, then lets the CPU run
//  for a programmed number of cycles. It then freezes architectural state and takes over regfile read

---
 rtl/run_dump_ctrl_if.sv | 20 ++
 rtl/run_dump_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/run_dump_ctrl_if.sv
// Register-dump stream between run_dump_ctrl and a host/bench sink.
// Handshake: a beat transfers on a rising clock edge where valid and ready
// are both 1. The master holds valid, idx and data stable from the cycle
// valid rises until that transfer; valid never drops without a transfer.
// ready may be asserted at any time and has no effect while valid is 0.
//   valid : master -> slave, beat present
//   ready : slave  -> master, sink accepts beat
//   idx   : master -> slave, register index of the beat
//   data  : master -> slave, register value of the beat
interface run_dump_ctrl_if #(
  parameter int IDX_W = 5
);
  logic             valid;
  logic             ready;
  logic [IDX_W-1:0] idx;
  logic [31:0]      data;

  modport master (output valid, output idx, output data, input ready);
  modport slave  (input valid, input idx, input data, output ready);
endinterface

// File: rtl/run_dump_ctrl.sv
// run_dump_ctrl: sequences one processor test run. On an accepted start it
// clears CPU and regfile for one cycle, lets the CPU run for the captured
// number of cycles, then freezes the CPU and borrows regfile read port A to
// stream every register out over the dump interface.
// Ports:
//   clock, reset    : clock (posedge), asynchronous active-low reset
//   start           : run request, honoured only in IDLE or DONE
//   num_cycles      : RUN length, captured when start is accepted
//   cpu_reset       : processor reset (high in IDLE and CLEAR)
//   rf_reset        : regfile clear (high in CLEAR only)
//   cpu_en          : high in RUN only; gates CPU/regfile write enables
//   cpu_rs1, rf_rs1 : processor read index in, muxed regfile read index out
//   rf_data_a       : regfile read-port-A data (combinational read)
//   dump            : dump stream master (valid/ready/idx/data)
//   cycle_count     : RUN cycles elapsed this run, saturating
//   busy, done      : CLEAR/RUN/DUMP_RD/DUMP_TX, and DONE
//   state_dbg       : current FSM state
module run_dump_ctrl #(
  parameter int REG_COUNT = 32,
  parameter int IDX_W     = 5,
  parameter int CYC_W     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CYC_W-1:0]   num_cycles,
  output logic               cpu_reset,
  output logic               rf_reset,
  output logic               cpu_en,
  input  logic [IDX_W-1:0]   cpu_rs1,
  output logic [IDX_W-1:0]   rf_rs1,
  input  logic [31:0]        rf_data_a,
  run_dump_ctrl_if.master    dump,
  output logic [CYC_W-1:0]   cycle_count,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DUMP_RD = 3'd3,
    ST_DUMP_TX = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CYC_W-1:0]   target_q;
  logic [CYC_W-1:0]   count_q;
  logic [IDX_W-1:0]   index_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        data_q;

  logic start_ok;
  logic run_last;
  logic beat_xfer;
  logic last_beat;

  assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  // RUN is only entered with target_q >= 1, so target_q - 1 cannot wrap here.
  assign run_last  = (count_q == target_q - CYC_W'(1));
  assign beat_xfer = (state_q == ST_DUMP_TX) && dump.ready;
  assign last_beat = (index_q == IDX_W'(REG_COUNT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_ok) state_d = ST_CLEAR;
      ST_CLEAR:   state_d = (target_q == '0) ? ST_DUMP_RD : ST_RUN;
      ST_RUN:     if (run_last) state_d = ST_DUMP_RD;
      ST_DUMP_RD: state_d = ST_DUMP_TX;
      ST_DUMP_TX: if (beat_xfer) state_d = last_beat ? ST_DONE : ST_DUMP_RD;
      ST_DONE:    if (start_ok) state_d = ST_CLEAR;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      target_q <= '0;
      count_q  <= '0;
      index_q  <= '0;
      idx_q    <= '0;
      data_q   <= '0;
    end else begin
      if (start_ok) begin
        target_q <= num_cycles;
        count_q  <= '0;
        index_q  <= '0;
      end
      if (state_q == ST_RUN && count_q != '1) begin
        count_q <= count_q + CYC_W'(1);
      end
      // The read index is already on rf_rs1 during DUMP_RD, so the
      // combinational read data is valid to capture at the end of it.
      if (state_q == ST_DUMP_RD) begin
        idx_q  <= index_q;
        data_q <= rf_data_a;
      end
      if (beat_xfer && !last_beat) begin
        index_q <= index_q + IDX_W'(1);
      end
    end
  end

  assign cpu_reset   = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
  assign rf_reset    = (state_q == ST_CLEAR);
  assign cpu_en      = (state_q == ST_RUN);
  assign busy        = (state_q == ST_CLEAR) || (state_q == ST_RUN) ||
                       (state_q == ST_DUMP_RD) || (state_q == ST_DUMP_TX);
  assign done        = (state_q == ST_DONE);
  assign rf_rs1      = (state_q == ST_DUMP_RD || state_q == ST_DUMP_TX) ? index_q : cpu_rs1;
  assign dump.valid  = (state_q == ST_DUMP_TX);
  assign dump.idx    = idx_q;
  assign dump.data   = data_q;
  assign cycle_count = count_q;
  assign state_dbg   = state_q;

endmodule
